arch_rat: RTL and testbench
===========================

Name: arch_rat

Overview:
- Committed (retirement) register alias table. It is the commit-side counterpart of the speculative rename RAT.
- Tracks the non-speculative arch→preg mapping for all 32 arch regs as up to 4 instructions retire per cycle.
- Returns each retired instruction's superseded (history) preg to the free list.
- On a flush from the ROB, drives a one-cycle recover pulse with the full committed mapping to the speculative RAT.

Parameters:
- PREG_W, 7, physical register index width; equals `PREG_INDEX_WIDTH.
- NUM_AREG, 32, number of architectural registers; fixed, not to be overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- commit_valid_vec  input  4  slot i retires this cycle; slot 0 oldest; valid slots are contiguous from 0
- commit_rd_exist_vec  input  4  slot i writes an arch rd
- commit_rd_index  input  5 x4  arch rd of slot i
- commit_new_preg  input  PREG_W x4  preg allocated to slot i at rename
- commit_history_preg  input  PREG_W x4  preg previously mapped to rd at rename (to be freed)
- commit_ready  output  1  arch_rat accepts commits; 0 while in RECOVER
- flush_req  input  1  ROB requests recovery after this cycle's commits (exception/mispredict at commit)
- recover_valid  output  1  one-cycle pulse; speculative RAT loads recover_preg_index_vec
- recover_preg_index_vec  output  PREG_W x32  committed mapping, direct view of the table register
- free_valid_vec  output  4  slot i returns a preg to the free list this cycle
- free_preg_index_vec  output  PREG_W x4  preg returned by slot i

Behaviour:
- Reset (async):
  - table[i] = i for i = 0..31.
  - recover_valid = 0, free_valid_vec = 0, free_preg_index_vec = 0.
  - FSM = IDLE, commit_ready = 1.
- Slot i commits when commit_ready & commit_valid_vec[i].
  - If commit_ready = 0, all commit inputs are ignored; the ROB must hold them.
- Table write, on the same clock edge as the commit:
  - For committing slots with rd_exist and rd_index != 0: table[rd_index] <= commit_new_preg.
  - Slots are applied in order 0→3. If two slots target the same rd, the highest slot's new_preg wins.
- table[0] is never written and always reads 0.
- Free output, registered, 1-cycle latency:
  - free_valid_vec[i] <= commit & rd_exist & rd_index != 0.
  - free_preg_index_vec[i] <= commit_history_preg[i] when valid, else 0.
  - Intra-group WAW: for slot j > i with the same rd, slot j's history_preg equals slot i's new_preg. Both history pregs are freed; no dedup is performed.
- FSM states: IDLE, RECOVER.
  - IDLE: flush_req = 1 → the same-cycle commits are applied (flush is ordered after them) → RECOVER.
  - RECOVER: recover_valid = 1 for exactly this cycle; commit_ready = 0; flush_req ignored; → IDLE.
  - recover_valid is the registered decode of state == RECOVER.
- recover_preg_index_vec is combinational from the table register. In RECOVER it reflects all commits up to and including the flush cycle.
- Frees from the flush cycle appear in the RECOVER cycle, concurrently with recover_valid.
- Back-to-back flush: flush_req asserted in RECOVER is dropped; the ROB must re-issue it after returning to IDLE.
- Reset asserted mid-RECOVER: the pulse is aborted and all state returns to reset values.
- No arithmetic; all indices are unsigned and used without wrap.

Test Plan:
- Reset then idle: recover_preg_index_vec[i] == i for all i; recover_valid = 0; free_valid_vec = 0; commit_ready = 1.
- Commit slot0 rd=5 new=40 hist=5 and slot1 rd=7 new=41 hist=7 → next cycle table[5]=40, table[7]=41; free_valid_vec=0011; free_preg[0]=5, free_preg[1]=7.
- Same-group WAW: slot0 rd=3 new=50 hist=3; slot2 rd=3 new=52 hist=50 → table[3]=52; free_valid_vec=0101; free pregs 3 and 50.
- rd=0 commit with new=60, and a commit with rd_exist=0 → table unchanged; free_valid for those slots = 0; table[0] stays 0.
- flush_req together with commit rd=9 new=70 hist=9:
  - Next cycle: recover_valid=1, recover vec[9]=70, free_valid[0]=1 with free preg 9, commit_ready=0.
  - Following cycle: recover_valid=0, commit_ready=1.
  - Commit inputs presented during RECOVER (rd=9 new=71) are ignored: table[9] stays 70.
- Assert rst_n low in the RECOVER cycle → recover_valid drops immediately and the table returns to identity.

Source files
------------

// File: rtl/arch_rat_if.sv
// Commit-side bundle between the ROB, the committed RAT, the free list and the speculative RAT.
// Slot 0 is the oldest retiring instruction; all vectors are packed with slot 0 at index 0.
interface arch_rat_if #(
  parameter int PREG_W = 7
);
  logic [3:0]             commit_valid_vec;
  logic [3:0]             commit_rd_exist_vec;
  logic [3:0][4:0]        commit_rd_index;
  logic [3:0][PREG_W-1:0] commit_new_preg;
  logic [3:0][PREG_W-1:0] commit_history_preg;
  logic                   commit_ready;
  logic                   flush_req;
  logic                   recover_valid;
  logic [31:0][PREG_W-1:0] recover_preg_index_vec;
  logic [3:0]             free_valid_vec;
  logic [3:0][PREG_W-1:0] free_preg_index_vec;

  // ROB side: drives commits and flush, observes recovery and frees
  modport master (
    output commit_valid_vec, commit_rd_exist_vec, commit_rd_index,
           commit_new_preg, commit_history_preg, flush_req,
    input  commit_ready, recover_valid, recover_preg_index_vec,
           free_valid_vec, free_preg_index_vec
  );

  // arch_rat side
  modport slave (
    input  commit_valid_vec, commit_rd_exist_vec, commit_rd_index,
           commit_new_preg, commit_history_preg, flush_req,
    output commit_ready, recover_valid, recover_preg_index_vec,
           free_valid_vec, free_preg_index_vec
  );
endinterface

// File: rtl/arch_rat.sv
// Committed register alias table: holds the non-speculative arch->preg map, frees superseded
// pregs at retirement and replays the whole committed map to the speculative RAT on flush.
module arch_rat #(
  parameter int PREG_W   = 7,
  parameter int NUM_AREG = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  arch_rat_if.slave    rat_if
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t                        state_r;
  logic                          commit_ready_r;
  logic                          recover_valid_r;
  logic [NUM_AREG-1:0][PREG_W-1:0] table_r;
  logic [NUM_AREG-1:0][PREG_W-1:0] table_nxt_s;
  logic [3:0]                    fire_s;
  logic [3:0]                    free_valid_r;
  logic [3:0][PREG_W-1:0]        free_preg_r;

  // Slots that actually retire and write a non-zero arch destination
  always_comb begin
    fire_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (commit_ready_r && rat_if.commit_valid_vec[i] && rat_if.commit_rd_exist_vec[i]
          && (rat_if.commit_rd_index[i] != 5'd0)) begin
        fire_s[i] = 1'b1;
      end else begin
        fire_s[i] = 1'b0;
      end
    end
  end

  // Next table: apply slots oldest first so the youngest writer of a shared rd wins
  always_comb begin
    table_nxt_s = table_r;
    for (int i = 0; i < 4; i++) begin
      if (fire_s[i]) begin
        table_nxt_s[rat_if.commit_rd_index[i]] = rat_if.commit_new_preg[i];
      end else begin
        table_nxt_s = table_nxt_s;
      end
    end
  end

  // Committed mapping storage; entry 0 stays 0 because fire_s excludes rd 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        table_r[i] <= PREG_W'(i);
      end
    end else begin
      table_r <= table_nxt_s;
    end
  end

  // Registered free-list return, one cycle after retirement (no WAW dedup)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_valid_r <= 4'b0000;
      free_preg_r  <= '0;
    end else begin
      free_valid_r <= fire_s;
      for (int i = 0; i < 4; i++) begin
        free_preg_r[i] <= fire_s[i] ? rat_if.commit_history_preg[i] : {PREG_W{1'b0}};
      end
    end
  end

  // Recovery FSM with registered ready/pulse outputs; a flush is ordered after same-cycle commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      commit_ready_r  <= 1'b1;
      recover_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rat_if.flush_req) begin
            state_r         <= ST_RECOVER;
            commit_ready_r  <= 1'b0;
            recover_valid_r <= 1'b1;
          end else begin
            state_r         <= ST_IDLE;
            commit_ready_r  <= 1'b1;
            recover_valid_r <= 1'b0;
          end
        end
        ST_RECOVER: begin
          state_r         <= ST_IDLE;
          commit_ready_r  <= 1'b1;
          recover_valid_r <= 1'b0;
        end
        default: begin
          state_r         <= ST_IDLE;
          commit_ready_r  <= 1'b1;
          recover_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rat_if.commit_ready           = commit_ready_r;
  assign rat_if.recover_valid          = recover_valid_r;
  assign rat_if.recover_preg_index_vec = table_r;
  assign rat_if.free_valid_vec         = free_valid_r;
  assign rat_if.free_preg_index_vec    = free_preg_r;

endmodule

// File: tb/tb_arch_rat.sv
// Directed bench for arch_rat: expected free/recover responses are queued at issue time and
// popped by an independent monitor whenever the DUT presents a free or recover output.
module tb_arch_rat;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  typedef struct {
    logic [3:0]      fv;
    logic [3:0][6:0] fp;
    logic            rv;
    logic            cr;
  } exp_t;

  exp_t exp_q[$];

  arch_rat_if #(.PREG_W(7)) rif ();

  arch_rat #(.PREG_W(7), .NUM_AREG(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rat_if (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rif.commit_valid_vec    = 4'b0000;
    rif.commit_rd_exist_vec = 4'b0000;
    rif.commit_rd_index     = '0;
    rif.commit_new_preg     = '0;
    rif.commit_history_preg = '0;
    rif.flush_req           = 1'b0;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] ex, input logic [3:0][4:0] rd,
                       input logic [3:0][6:0] nw, input logic [3:0][6:0] hs, input logic fl);
    rif.commit_valid_vec    = v;
    rif.commit_rd_exist_vec = ex;
    rif.commit_rd_index     = rd;
    rif.commit_new_preg     = nw;
    rif.commit_history_preg = hs;
    rif.flush_req           = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic push(input logic [3:0] fv, input logic [3:0][6:0] fp, input logic rv, input logic cr);
    exp_t e;
    e.fv = fv; e.fp = fp; e.rv = rv; e.cr = cr;
    exp_q.push_back(e);
  endtask

  task automatic chk_identity(input string name);
    for (int i = 0; i < 32; i++) begin
      chk(name, 32'(rif.recover_preg_index_vec[i]), 32'(i));
    end
  endtask

  // Monitor: any free or recover activity must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ((rif.free_valid_vec != 4'b0000) || rif.recover_valid)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: fv=%b rv=%b with nothing expected",
                   rif.free_valid_vec, rif.recover_valid);
        end else begin
          e = exp_q.pop_front();
          chk("mon_free_valid", 32'(rif.free_valid_vec), 32'(e.fv));
          for (int i = 0; i < 4; i++) begin
            chk("mon_free_preg", 32'(rif.free_preg_index_vec[i]), 32'(e.fp[i]));
          end
          chk("mon_recover_valid", 32'(rif.recover_valid), 32'(e.rv));
          chk("mon_commit_ready", 32'(rif.commit_ready), 32'(e.cr));
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk_identity("reset_table");
    chk("reset_recover_valid", 32'(rif.recover_valid), 32'd0);
    chk("reset_free_valid", 32'(rif.free_valid_vec), 32'd0);
    chk("reset_free_preg0", 32'(rif.free_preg_index_vec[0]), 32'd0);
    chk("reset_commit_ready", 32'(rif.commit_ready), 32'd1);

    // Two-slot commit
    @(posedge clk); #1;
    drive(4'b0011, 4'b0011, {5'd0, 5'd0, 5'd7, 5'd5}, {7'd0, 7'd0, 7'd41, 7'd40},
          {7'd0, 7'd0, 7'd7, 7'd5}, 1'b0);
    push(4'b0011, {7'd0, 7'd0, 7'd7, 7'd5}, 1'b0, 1'b1);
    step();
    chk("t1_table5", 32'(rif.recover_preg_index_vec[5]), 32'd40);
    chk("t1_table7", 32'(rif.recover_preg_index_vec[7]), 32'd41);
    chk("t1_table6", 32'(rif.recover_preg_index_vec[6]), 32'd6);

    // Same-group WAW on rd 3: youngest writer wins, both history pregs freed
    drive(4'b0111, 4'b0101, {5'd0, 5'd3, 5'd4, 5'd3}, {7'd0, 7'd52, 7'd51, 7'd50},
          {7'd0, 7'd50, 7'd4, 7'd3}, 1'b0);
    push(4'b0101, {7'd0, 7'd50, 7'd0, 7'd3}, 1'b0, 1'b1);
    step();
    chk("t2_table3", 32'(rif.recover_preg_index_vec[3]), 32'd52);
    chk("t2_table4", 32'(rif.recover_preg_index_vec[4]), 32'd4);

    // rd 0 and rd_exist=0 commits change nothing and free nothing
    drive(4'b0011, 4'b0001, {5'd0, 5'd0, 5'd8, 5'd0}, {7'd0, 7'd0, 7'd61, 7'd60},
          {7'd0, 7'd0, 7'd8, 7'd0}, 1'b0);
    step();
    chk("t3_table0", 32'(rif.recover_preg_index_vec[0]), 32'd0);
    chk("t3_table8", 32'(rif.recover_preg_index_vec[8]), 32'd8);
    chk("t3_free_valid", 32'(rif.free_valid_vec), 32'd0);

    // Flush with a same-cycle commit
    drive(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, {7'd0, 7'd0, 7'd0, 7'd70},
          {7'd0, 7'd0, 7'd0, 7'd9}, 1'b1);
    push(4'b0001, {7'd0, 7'd0, 7'd0, 7'd9}, 1'b1, 1'b0);
    step();
    chk("t4_recover_valid", 32'(rif.recover_valid), 32'd1);
    chk("t4_recover_vec9", 32'(rif.recover_preg_index_vec[9]), 32'd70);
    chk("t4_commit_ready", 32'(rif.commit_ready), 32'd0);
    // Commit and flush offered during RECOVER must be ignored
    drive(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, {7'd0, 7'd0, 7'd0, 7'd71},
          {7'd0, 7'd0, 7'd0, 7'd70}, 1'b1);
    step();
    chk("t4_table9_kept", 32'(rif.recover_preg_index_vec[9]), 32'd70);
    chk("t4_pulse_done", 32'(rif.recover_valid), 32'd0);
    chk("t4_ready_back", 32'(rif.commit_ready), 32'd1);
    chk("t4_no_free", 32'(rif.free_valid_vec), 32'd0);
    step();
    chk("t4_flush_dropped", 32'(rif.recover_valid), 32'd0);

    // Second flush, then reset in the RECOVER cycle
    drive(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd10}, {7'd0, 7'd0, 7'd0, 7'd72},
          {7'd0, 7'd0, 7'd0, 7'd10}, 1'b1);
    push(4'b0001, {7'd0, 7'd0, 7'd0, 7'd10}, 1'b1, 1'b0);
    step();
    chk("t5_recover_valid", 32'(rif.recover_valid), 32'd1);
    chk("t5_table10", 32'(rif.recover_preg_index_vec[10]), 32'd72);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_recover_valid", 32'(rif.recover_valid), 32'd0);
    chk("t5_rst_commit_ready", 32'(rif.commit_ready), 32'd1);
    chk("t5_rst_free_valid", 32'(rif.free_valid_vec), 32'd0);
    chk_identity("t5_rst_table");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
